// File: rtl/bpsk_pkg.sv
// Shared types, default timing parameters and helpers for the BPSK serializer
// and phase generator.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_TAIL
  } state_e;

  localparam int unsigned DEF_WAVELENGTH       = 16;
  localparam int unsigned DEF_CARRIERS_PER_BIT = 4;
  localparam int unsigned DEF_PREAMBLE_BITS    = 8;
  localparam int unsigned DEF_TAIL_BITS        = 2;

  function automatic int unsigned bit_clocks(input int unsigned wavelength,
                                             input int unsigned carriers_per_bit);
    return wavelength * carriers_per_bit;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bpsk_bit_timer.sv
// Modulo-BIT_CLOCKS symbol timer; bit_end_c_o flags the last clock of each bit period.
module bpsk_bit_timer #(
  parameter int unsigned BIT_CLOCKS = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic restart_i,
  output logic bit_end_c_o
);

  localparam int unsigned TW = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;

  logic [TW-1:0] count_q, count_d;

  assign bit_end_c_o = enable_i && (count_q == TW'(BIT_CLOCKS - 1));

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (bit_end_c_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/bpsk_bit_serializer.sv
// Frames payload bytes as preamble / payload (MSB first) / tail zeros, one line bit
// per symbol period. Define BPSK_DIFF_ENC_EN for differential payload/tail encoding.
module bpsk_bit_serializer
  import bpsk_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH       = 8,
  parameter int unsigned WAVELENGTH       = DEF_WAVELENGTH,
  parameter int unsigned CARRIERS_PER_BIT = DEF_CARRIERS_PER_BIT,
  parameter int unsigned PREAMBLE_BITS    = DEF_PREAMBLE_BITS,
  parameter int unsigned TAIL_BITS        = DEF_TAIL_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  data,
  output logic                  tx_active,
  output logic                  symbol_strobe,
  output logic                  underrun,
  output logic                  frame_done
);

  localparam int unsigned BIT_CLOCKS = bit_clocks(WAVELENGTH, CARRIERS_PER_BIT);
  localparam int unsigned MAX_BITS   = max3(PREAMBLE_BITS, TAIL_BITS, BYTE_WIDTH);
  localparam int unsigned CW         = $clog2(MAX_BITS);

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BYTE_WIDTH-1:0] shift_q, shift_d;
  logic                  last_q, last_d;
  logic [BYTE_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_last_q, hold_last_d;
  logic                  hold_full_q, hold_full_d;
  logic                  data_q, data_d;
  logic                  tx_active_q, tx_active_d;
  logic                  strobe_q, strobe_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_done_q, frame_done_d;
  logic                  restart_c, bit_end_c, xfer_c, ref_c;

  assign xfer_c        = in_valid && !hold_full_q;
  assign in_ready      = !hold_full_q;
  assign data          = data_q;
  assign tx_active     = tx_active_q;
  assign symbol_strobe = strobe_q;
  assign underrun      = underrun_q;
  assign frame_done    = frame_done_q;

  // Encoding reference: the previous line bit, or a constant 0 for plain NRZ.
`ifdef BPSK_DIFF_ENC_EN
  assign ref_c = data_q;
`else
  assign ref_c = 1'b0;
`endif

  bpsk_bit_timer #(
    .BIT_CLOCKS(BIT_CLOCKS)
  ) u_bit_timer (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (state_q != ST_IDLE),
    .restart_i  (restart_c),
    .bit_end_c_o(bit_end_c)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    last_d       = last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    data_d       = data_q;
    tx_active_d  = tx_active_q;
    strobe_d     = 1'b0;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    restart_c    = 1'b0;

    if (xfer_c) begin
      hold_d      = in_data;
      hold_last_d = in_last;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A byte left in hold by the previous frame starts the next one.
        if (xfer_c || hold_full_q) begin
          state_d     = ST_PREAMBLE;
          restart_c   = 1'b1;
          bit_cnt_d   = '0;
          data_d      = 1'b1;
          tx_active_d = 1'b1;
          strobe_d    = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (bit_end_c) begin
          strobe_d = 1'b1;
          if (bit_cnt_q == CW'(PREAMBLE_BITS - 1)) begin
            state_d     = ST_PAYLOAD;
            bit_cnt_d   = '0;
            shift_d     = hold_q;
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
            data_d      = ref_c ^ hold_q[BYTE_WIDTH-1];
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            data_d    = !data_q;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bit_end_c) begin
          strobe_d = 1'b1;
          if (bit_cnt_q == CW'(BYTE_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (!last_q && hold_full_q) begin
              shift_d     = hold_q;
              last_d      = hold_last_q;
              hold_full_d = 1'b0;
              data_d      = ref_c ^ hold_q[BYTE_WIDTH-1];
            end else begin
              state_d    = ST_TAIL;
              underrun_d = !last_q;
              data_d     = ref_c;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = {shift_q[BYTE_WIDTH-2:0], shift_q[BYTE_WIDTH-1]};
            data_d    = ref_c ^ shift_q[BYTE_WIDTH-2];
          end
        end
      end
      ST_TAIL: begin
        if (bit_end_c) begin
          if (bit_cnt_q == CW'(TAIL_BITS - 1)) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            data_d       = 1'b0;
            tx_active_d  = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            strobe_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            data_d    = ref_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      data_q       <= 1'b0;
      tx_active_q  <= 1'b0;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      data_q       <= data_d;
      tx_active_q  <= tx_active_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// Scoreboard bench for bpsk_bit_serializer: frame-level model queues expected line bits,
// a negedge monitor checks every strobe and frame end. Honors BPSK_DIFF_ENC_EN.
`timescale 1ns/1ps
module tb_bpsk_bit_serializer;

  localparam int BW   = 8;
  localparam int PRE  = 8;
  localparam int TAIL = 2;
  localparam int BITC = 64;
`ifdef BPSK_DIFF_ENC_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, data, tx_active, symbol_strobe, underrun, frame_done;

  always #5 clock = ~clock;

  bpsk_bit_serializer dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data         (data),
    .tx_active    (tx_active),
    .symbol_strobe(symbol_strobe),
    .underrun     (underrun),
    .frame_done   (frame_done)
  );

  typedef struct packed { logic b; logic first; } exp_bit_t;
  typedef struct packed { int unsigned nbits; logic und; } exp_frm_t;

  exp_bit_t    exp_q[$];
  exp_frm_t    frm_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_strobe_cyc = 0;
  int unsigned strobes_in_frame = 0;
  int unsigned und_seen = 0;
  int unsigned last_done_cyc = 0;
  logic        prev_data = 1'b0;
  exp_bit_t    mon_e;
  exp_frm_t    mon_f;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line_bit(input logic prev, input logic src);
    return src ^ (DIFF & prev);
  endfunction

  // Reference model: whole-frame line bit sequence straight from the framing rules.
  task automatic push_frame(input logic [7:0] bytes[$], input bit starve);
    exp_bit_t    e;
    exp_frm_t    fr;
    logic        prev;
    logic [7:0]  b;
    int unsigned n;
    n = 0;
    for (int i = 0; i < PRE; i++) begin
      e.b = (i % 2 == 0);
      e.first = (i == 0);
      exp_q.push_back(e);
      n++;
    end
    prev = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      b = bytes[i];
      for (int j = BW - 1; j >= 0; j--) begin
        e.b = line_bit(prev, b[j]);
        e.first = 1'b0;
        prev = e.b;
        exp_q.push_back(e);
        n++;
      end
    end
    for (int i = 0; i < TAIL; i++) begin
      e.b = line_bit(prev, 1'b0);
      e.first = 1'b0;
      prev = e.b;
      exp_q.push_back(e);
      n++;
    end
    fr.nbits = n;
    fr.und = starve;
    frm_q.push_back(fr);
  endtask

  // Monitor: pops the scoreboard on every strobe and every frame end.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      strobes_in_frame = 0;
      und_seen = 0;
      prev_data = 1'b0;
    end else begin
      if (data !== prev_data) check("data_change_off_strobe", symbol_strobe | frame_done, 1);
      prev_data = data;
      if (symbol_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("line_bit", data, mon_e.b);
          check("tx_active_on_strobe", tx_active, 1);
          if (mon_e.first) strobes_in_frame = 0;
          else check("strobe_spacing", cyc - last_strobe_cyc, BITC);
          strobes_in_frame++;
          last_strobe_cyc = cyc;
        end
      end
      if (underrun) begin
        und_seen++;
        check("underrun_with_strobe", symbol_strobe, 1);
      end
      if (frame_done) begin
        check("tx_active_at_done", tx_active, 0);
        check("done_after_last_strobe", cyc - last_strobe_cyc, BITC);
        if (frm_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          mon_f = frm_q.pop_front();
          check("strobes_per_frame", strobes_in_frame, mon_f.nbits);
          check("underrun_pulses", und_seen, mon_f.und);
        end
        und_seen = 0;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, output int unsigned acc);
    int unsigned budget;
    budget = 0;
    acc = 0;
    in_data = b;
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && budget < 5000) begin
      @(negedge clock);
      #1;
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    check("in_ready_low_after_accept", in_ready, 0);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit starve,
                            output int unsigned first_acc);
    int unsigned a;
    first_acc = 0;
    push_frame(bytes, starve);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], 1'(!starve && (i == bytes.size() - 1)), a);
      if (i == 0) first_acc = a;
    end
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || frm_q.size() != 0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("drain", exp_q.size() + frm_q.size(), 0);
  endtask

  initial begin
    int unsigned t, n;
    bit          starve;
    logic [7:0]  q[$];

    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("reset_outputs", {data, tx_active, symbol_strobe, underrun, frame_done}, 0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Single byte with last: first bit right after acceptance, done 1153 cycles later.
    q = '{8'hA5};
    send_frame(q, 1'b0, t);
    check("first_strobe_after_accept", {tx_active, symbol_strobe, data}, 3'b111);
    wait_drain();
    check("frame_done_latency", last_done_cyc - (t - 1), 1153);

    // Back-to-back bytes with no gap.
    q = '{8'h00, 8'hFF, 8'h0F};
    send_frame(q, 1'b0, t);
    wait_drain();

    // Underrun after a byte without last.
    q = '{8'h3C};
    send_frame(q, 1'b1, t);
    wait_drain();

    // Asynchronous reset mid-payload, then a fresh frame with full preamble.
    q = '{8'h5A};
    send_frame(q, 1'b0, t);
    repeat (599) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {data, tx_active, symbol_strobe, underrun, frame_done}, 0);
    exp_q.delete();
    frm_q.delete();
    @(negedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("in_ready_after_mid_reset", in_ready, 1);
    q = '{8'hC3};
    send_frame(q, 1'b0, t);
    wait_drain();

    // Randomized frames, some pipelined behind the previous frame, some starved.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 3);
      starve = ($urandom_range(0, 3) == 0);
      q.delete();
      for (int i = 0; i < int'(n); i++) q.push_back(8'($urandom));
      send_frame(q, starve, t);
      if (starve || $urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
